// File: rtl/regfile_wr_arb.sv
// rtl/regfile_wr_arb.sv - round-robin write-port arbiter and clear sequencer for the register file
// Optional feature: define REGFILE_R0_PROTECT_EN to make register 0 read-only zero.
module regfile_wr_arb #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Req0,
    input  logic [AW-1:0] Adrs0,
    input  logic [DW-1:0] Data0,
    output logic          Gnt0,
    input  logic          Req1,
    input  logic [AW-1:0] Adrs1,
    input  logic [DW-1:0] Data1,
    output logic          Gnt1,
    input  logic          Clr,
    output logic          Busy,
    output logic          LdReg,
    output logic [AW-1:0] WtAdrs,
    output logic [DW-1:0] WtData
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AW-1:0] LAST_ADRS = '1;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ptr_q, ptr_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          busy_q, busy_d;
    logic          ld_q, ld_d;
    logic [AW-1:0] wtadrs_q, wtadrs_d;
    logic [DW-1:0] wtdata_q, wtdata_d;

    logic          elig0, elig1, pick1, write_ok;
    logic [AW-1:0] sel_adrs;
    logic [DW-1:0] sel_data;

    // A requester holding its request across its own grant cycle is not re-granted.
    assign elig0    = Req0 & ~gnt0_q;
    assign elig1    = Req1 & ~gnt1_q;
    assign pick1    = elig1 & (~elig0 | ptr_q);
    assign sel_adrs = pick1 ? Adrs1 : Adrs0;
    assign sel_data = pick1 ? Data1 : Data0;

`ifdef REGFILE_R0_PROTECT_EN
    assign write_ok = (sel_adrs != '0);
`else
    assign write_ok = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        busy_d   = 1'b0;
        ld_d     = 1'b0;
        wtadrs_d = wtadrs_q;
        wtdata_d = wtdata_q;
        case (state_q)
            IDLE: begin
                if (Clr) begin
                    // The first clear write (address 0) is issued at the entry edge.
                    state_d  = CLEAR;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    ld_d     = 1'b1;
                    wtadrs_d = '0;
                    wtdata_d = '0;
                end else if (elig0 | elig1) begin
                    gnt0_d = ~pick1;
                    gnt1_d = pick1;
                    ptr_d  = ~pick1;
                    if (write_ok) begin
                        ld_d     = 1'b1;
                        wtadrs_d = sel_adrs;
                        wtdata_d = sel_data;
                    end
                end
            end
            CLEAR: begin
                cnt_d    = cnt_q + AW'(1);
                busy_d   = 1'b1;
                ld_d     = 1'b1;
                wtadrs_d = cnt_d;
                wtdata_d = '0;
                if (cnt_d == LAST_ADRS) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            busy_q   <= 1'b0;
            ld_q     <= 1'b0;
            wtadrs_q <= '0;
            wtdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            busy_q   <= busy_d;
            ld_q     <= ld_d;
            wtadrs_q <= wtadrs_d;
            wtdata_q <= wtdata_d;
        end
    end

    assign Gnt0   = gnt0_q;
    assign Gnt1   = gnt1_q;
    assign Busy   = busy_q;
    assign LdReg  = ld_q;
    assign WtAdrs = wtadrs_q;
    assign WtData = wtdata_q;
endmodule
